// File: rtl/dense_mac_output.sv
// Fully-connected output layer: N_OUT parallel time-multiplexed MACs over N_IN inputs,
// with runtime-loadable weights/biases and a rounded, saturated fixed-point result.
module dense_mac_output #(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 1,
  parameter int DATA_W = 16,
  parameter int FRAC   = 12,
  parameter int ACC_W  = 40,
  parameter int ROUND  = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [N_IN*DATA_W-1:0]                       in_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [N_OUT*DATA_W-1:0]                      out_data,
  output logic [N_OUT-1:0]                             out_sat,
  input  logic                                         w_we,
  input  logic [$clog2(N_OUT*N_IN)-1:0]                w_addr,
  input  logic [DATA_W-1:0]                            w_data,
  input  logic                                         b_we,
  input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] b_addr,
  input  logic [DATA_W-1:0]                            b_data,
  output logic                                         cfg_busy
);

  localparam int W_AW = $clog2(N_OUT*N_IN);
  localparam int B_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int K_W  = $clog2(N_IN);
  localparam int P_W  = 2*DATA_W;

  localparam logic [W_AW:0]  W_DEPTH = (W_AW+1)'(N_OUT*N_IN);
  localparam logic [B_AW:0]  B_DEPTH = (B_AW+1)'(N_OUT);
  localparam logic [K_W-1:0] K_LAST  = K_W'(N_IN-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state;
  logic [K_W-1:0]           k_p0;
  logic                     accept;
  logic                     cfg_open;

  logic signed [DATA_W-1:0] in_p0    [N_IN];
  logic signed [DATA_W-1:0] w_mem    [N_OUT*N_IN];
  logic signed [DATA_W-1:0] b_mem    [N_OUT];
  logic signed [P_W-1:0]    prod_p1  [N_OUT];
  logic signed [ACC_W-1:0]  acc_p1   [N_OUT];
  logic signed [DATA_W-1:0] fin_data [N_OUT];
  logic [N_OUT-1:0]         fin_sat;
  logic signed [DATA_W-1:0] out_p2   [N_OUT];

  // Optional round-half-up, then arithmetic shift back to FRAC fractional bits.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] half;
    logic signed [ACC_W-1:0] t;
    half = '0;
    half[FRAC-1] = 1'b1;
    t = (ROUND != 0) ? a + half : a;
    return t >>> FRAC;
  endfunction

  // Clamp to the DATA_W signed range; MSB of the result is the saturation flag.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W:0] s);
    logic signed [ACC_W:0] max_v;
    logic signed [ACC_W:0] min_v;
    max_v = '0;
    max_v[DATA_W-2:0] = '1;
    min_v = '1;
    min_v[DATA_W-2:0] = '0;
    if (s > max_v) begin
      return {1'b1, max_v[DATA_W-1:0]};
    end else if (s < min_v) begin
      return {1'b1, min_v[DATA_W-1:0]};
    end else begin
      return {1'b0, s[DATA_W-1:0]};
    end
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign cfg_busy  = (state != S_IDLE);
  assign accept    = (state == S_IDLE) && in_valid;
  assign cfg_open  = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      k_p0  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_MAC;
            k_p0  <= '0;
          end
        end
        S_MAC: begin
          k_p0 <= k_p0 + K_W'(1);
          if (k_p0 == K_LAST) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          state <= S_OUT;
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Config writes land only while idle, including the cycle a vector is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_OUT*N_IN; i++) begin
        w_mem[W_AW'(i)] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        b_mem[B_AW'(j)] <= '0;
      end
    end else if (cfg_open) begin
      if (w_we && ({1'b0, w_addr} < W_DEPTH)) begin
        w_mem[w_addr] <= w_data;
      end
      if (b_we && ({1'b0, b_addr} < B_DEPTH)) begin
        b_mem[b_addr] <= b_data;
      end
    end
  end

  // Stage p1: one product per neuron for the current input index.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      prod_p1[B_AW'(j)] = in_p0[k_p0] * w_mem[W_AW'(j*N_IN) + W_AW'(k_p0)];
    end
  end

  // Stage p2: round, add bias, saturate.
  always_comb begin
    fin_sat = '0;
    for (int j = 0; j < N_OUT; j++) begin
      logic signed [ACC_W-1:0] r;
      logic signed [ACC_W:0]   s;
      logic [DATA_W:0]         q;
      r = round_shift(acc_p1[B_AW'(j)]);
      s = {r[ACC_W-1], r}
        + {{(ACC_W+1-DATA_W){b_mem[B_AW'(j)][DATA_W-1]}}, b_mem[B_AW'(j)]};
      q = saturate(s);
      fin_sat[B_AW'(j)]  = q[DATA_W];
      fin_data[B_AW'(j)] = q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_IN; i++) begin
        in_p0[K_W'(i)] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        acc_p1[B_AW'(j)] <= '0;
        out_p2[B_AW'(j)] <= '0;
      end
      out_sat <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_IN; i++) begin
          in_p0[K_W'(i)] <= in_data[i*DATA_W +: DATA_W];
        end
        for (int j = 0; j < N_OUT; j++) begin
          acc_p1[B_AW'(j)] <= '0;
        end
      end
      if (state == S_MAC) begin
        for (int j = 0; j < N_OUT; j++) begin
          acc_p1[B_AW'(j)] <= acc_p1[B_AW'(j)]
            + {{(ACC_W-P_W){prod_p1[B_AW'(j)][P_W-1]}}, prod_p1[B_AW'(j)]};
        end
      end
      if (state == S_FINAL) begin
        for (int j = 0; j < N_OUT; j++) begin
          out_p2[B_AW'(j)] <= fin_data[B_AW'(j)];
        end
        out_sat <= fin_sat;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N_OUT; j++) begin
      out_data[j*DATA_W +: DATA_W] = out_p2[B_AW'(j)];
    end
  end

endmodule

// File: doc/dense_mac_output.md
Name: dense_mac_output

Overview:
Parametrised fully-connected output layer for the PPG-to-CO regression network. It computes N_OUT neurons, each a weighted sum of N_IN fixed-point inputs plus a bias. It uses one time-multiplexed MAC per neuron, so a result takes N_IN cycles. Weights and biases are runtime-loadable, the result is saturated, and the block has valid/ready handshakes on input and output.

Parameters:
N_IN, 16, inputs per neuron (>=2)
N_OUT, 1, number of output neurons (parallel MACs)
DATA_W, 16, width of data, weight and bias words (signed two's complement)
FRAC, 12, fractional bits shared by data, weights, bias and output (Q4.12 at defaults; >=1)
ACC_W, 40, accumulator width (>= 2*DATA_W + clog2(N_IN))
ROUND, 1, 1 = round-half-up before the FRAC shift; 0 = truncate (arithmetic shift)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  N_IN*DATA_W  packed signed inputs; element i at [i*DATA_W +: DATA_W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  N_OUT*DATA_W  packed signed results; neuron j at [j*DATA_W +: DATA_W]
out_sat  out  N_OUT  per-neuron saturation flag, qualified by out_valid
w_we  in  1  weight write strobe
w_addr  in  clog2(N_OUT*N_IN)  weight index = j*N_IN + i
w_data  in  DATA_W  weight value
b_we  in  1  bias write strobe
b_addr  in  max(1,clog2(N_OUT))  bias index j
b_data  in  DATA_W  bias value
cfg_busy  out  1  high when state != IDLE; weight/bias writes are ignored while high

Behaviour:
- Reset (reset_n low, async): state IDLE; in_ready=1; out_valid=0; out_data=0; out_sat=0; cfg_busy=0; accumulators, MAC index, all weights and all biases cleared to 0.
- FSM states: IDLE, MAC, FINAL, OUT.
- IDLE: in_ready=1. On an edge with in_valid=1, latch in_data into the input register, clear the accumulators, set index k=0, and go to MAC.
- MAC: on each edge, acc[j] += in[k]*w[j][k] for all j, and k increments. The product is a full 2*DATA_W-bit signed value, sign-extended to ACC_W. After the edge where k=N_IN-1, go to FINAL. MAC therefore takes exactly N_IN edges.
- FINAL, one edge:
  - r = ROUND ? (acc + 2^(FRAC-1)) >>> FRAC : acc >>> FRAC.
  - s = r + sign-extended bias[j].
  - Clamp s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat[j]=1 if clamped, else 0.
  - Register the clamped value into out_data and go to OUT with out_valid=1.
- Latency: acceptance edge T -> out_valid high after edge T+N_IN+1.
- OUT: out_valid=1; out_data and out_sat are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE with out_valid=0. out_data keeps its last value but is not qualified.
- in_ready is high only in IDLE. There is no input acceptance in MAC, FINAL or OUT, and no overlap of accept with the output handshake. Throughput is one vector per N_IN+3 cycles minimum.
- in_data is sampled only on the acceptance edge. Changes to it afterwards have no effect.
- Config writes:
  - Take effect on the edge only when in IDLE.
  - w_we and b_we may be asserted in the same cycle.
  - A write to an address >= N_OUT*N_IN (weights) or >= N_OUT (biases) is ignored.
  - A write in the same IDLE cycle as an in_valid acceptance takes effect; MAC uses the new value.
- reset_n asserted in any state aborts the operation immediately and returns everything to the reset values, including the weights.

Test Plan:
1. N_IN=16, N_OUT=2, ROUND=1:
   - Configuration: w[0][*]=256, b[0]=510; w[1][*]=-256, b[1]=0.
   - Stimulus: all inputs 4096.
   - Required: out_data = {-4096, 4606}, out_sat=00, out_valid rising exactly 17 edges after acceptance.
2. Saturation: w[0][*]=32767, inputs all 32767 -> out_data[0]=32767, out_sat[0]=1. Then w[0][*]=-32768 -> out_data[0]=-32768, out_sat[0]=1.
3. Rounding:
   - Stimulus: in[0]=1, w[0][0]=2048, all other weights 0, bias 0.
   - Required: ROUND=1 -> 1; ROUND=0 -> 0.
   - Also: in[0]=-1 gives 0 with ROUND=1 and -1 with ROUND=0.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid -> out_data and out_valid stable, in_ready=0.
   - A w_we pulse during this window is ignored; the next vector reproduces the identical result.
5. Reset mid-MAC: drop reset_n at MAC k=5 -> out_valid=0, in_ready=1 asynchronously, and weights read back as 0 (the next vector yields the bias-only value 0).
6. Out-of-range config: w_addr=N_OUT*N_IN and b_addr=N_OUT (when the index width allows it) -> no weight or bias changes, and the result of scenario 1 is unchanged.
